// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
//   Bundles the fetch port, the data-memory port and the SRAM port that meet
//   at sram_arbiter.
//
//   modport slave  : the arbiter. It takes requests and SRAM read data, and
//                    drives grants, read responses and the SRAM controls.
//   modport master : the requesters and the SRAM side (used by the bench).
//
//   Fetch port  : if_req, if_addr            -> if_gnt, if_rvalid, if_rdata
//   Data port   : mem_req, mem_we, mem_wstrb,
//                 mem_addr, mem_wdata        -> mem_gnt, mem_rvalid, mem_rdata
//   SRAM port   : sram_rdata                 -> sram_en, sram_we, sram_addr,
//                                               sram_wdata
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Instruction-fetch port (read only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Data-memory port
  logic              mem_req;
  logic              mem_we;
  logic [STRB_W-1:0] mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // Single-port synchronous SRAM
  logic              sram_en;
  logic [STRB_W-1:0] sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Shares one single-port synchronous SRAM between the instruction-fetch port
//   and the data-memory port. At most one access is granted per cycle, in the
//   same cycle it is requested. Read data (1-cycle SRAM latency) is steered
//   back to whichever port issued the read.
//
//   Priority: MEM wins by default. Every cycle IF asks and is refused bumps a
//   starvation counter; once it reaches STARVE_LIMIT, IF wins the next
//   arbitration and the counter clears.
//
//   Ports:
//     clk    : clock
//     reset  : synchronous, active-high reset
//     bus    : sram_arbiter_if.slave (fetch, data and SRAM signals)
//
//   Parameters:
//     ADDR_W       : address width (both ports and the SRAM)
//     DATA_W       : data width, DATA_W/8 byte strobes
//     STARVE_LIMIT : consecutive IF denials before IF is forced, 1..15
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);

  localparam int STRB_W = DATA_W / 8;

  // The counter is 4 bits wide, so the limit has to fit in 1..15.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Owner of the read response returning in the next cycle.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [1:0] rsp_owner_q,  rsp_owner_d;

  logic force_if;
  logic if_gnt;
  logic mem_gnt;

  // ---------------------------------------------------------------------------
  // Grant logic. Purely combinational so a requester is served in the cycle it
  // asks. Both grants are held low during reset, so nothing reaches the SRAM.
  // ---------------------------------------------------------------------------
  always_comb begin
    force_if = (starve_cnt_q == LIMIT);
    if_gnt   = ~reset & bus.if_req & (~bus.mem_req | force_if);
    mem_gnt  = ~reset & bus.mem_req & ~if_gnt;
  end

  // ---------------------------------------------------------------------------
  // SRAM drive. With no grant the address defaults to the MEM address and the
  // write enables stay low, so the SRAM sees a quiet, defined bus.
  // ---------------------------------------------------------------------------
  assign bus.sram_en    = if_gnt | mem_gnt;
  assign bus.sram_addr  = if_gnt ? bus.if_addr : bus.mem_addr;
  assign bus.sram_we    = (mem_gnt & bus.mem_we) ? bus.mem_wstrb : '0;
  assign bus.sram_wdata = bus.mem_wdata;

  assign bus.if_gnt  = if_gnt;
  assign bus.mem_gnt = mem_gnt;

  // ---------------------------------------------------------------------------
  // Next-state logic for the starvation counter and response owner.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rsp_owner_d  = OWN_NONE;

    // A served or idle IF port has nothing to remember; only consecutive
    // refusals count, and the count stops at the limit.
    if (if_gnt || !bus.if_req) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Writes complete at the clock edge and return nothing.
    if (if_gnt) begin
      rsp_owner_d = OWN_IF;
    end else if (mem_gnt && !bus.mem_we) begin
      rsp_owner_d = OWN_MEM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      rsp_owner_q  <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read response path. The owner register is only cleared at the edge that
  // samples reset, so the valids are also masked by reset directly: a read
  // granted in the cycle before reset is dropped instead of surfacing while
  // reset is high.
  // ---------------------------------------------------------------------------
  assign bus.if_rvalid  = ~reset & (rsp_owner_q == OWN_IF);
  assign bus.mem_rvalid = ~reset & (rsp_owner_q == OWN_MEM);
  assign bus.if_rdata   = bus.sram_rdata;
  assign bus.mem_rdata  = bus.sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter (STARVE_LIMIT = 4). A small behavioural
//   SRAM is attached to the SRAM port; its word k is preloaded with k*0x11,
//   except word 8 (address 0x20) which holds 0x11223344.
//
//   Inputs are driven on the falling edge and outputs are compared 1 ns later,
//   well away from the rising edge. A table of one-cycle vectors covers reset,
//   fetch streaming, byte writes, reset mid-read and MEM-over-IF priority;
//   hand-written sequences cover continuous contention and the counter clear.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk;
  logic reset;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural single-port SRAM, 256 words, 1-cycle read latency.
  // ---------------------------------------------------------------------------
  logic [31:0] sram_mem [256];

  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we == 4'b0000) begin
        bus.sram_rdata <= sram_mem[bus.sram_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.sram_we[b]) sram_mem[bus.sram_addr[9:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic mr, input logic mw, input logic [3:0] ms,
                       input logic [31:0] ma, input logic [31:0] md);
    reset         = rst;
    bus.if_req    = ir;
    bus.if_addr   = ia;
    bus.mem_req   = mr;
    bus.mem_we    = mw;
    bus.mem_wstrb = ms;
    bus.mem_addr  = ma;
    bus.mem_wdata = md;
  endtask

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        mr;
    logic        mw;
    logic [3:0]  ms;
    logic [31:0] ma;
    logic [31:0] md;
    logic        e_ig;
    logic        e_mg;
    logic        e_en;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic        e_irv;
    logic        e_mrv;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t v(logic rst, logic ir, logic [31:0] ia, logic mr, logic mw,
                             logic [3:0] ms, logic [31:0] ma, logic [31:0] md,
                             logic e_ig, logic e_mg, logic e_en, logic [3:0] e_we,
                             logic [31:0] e_addr, logic e_irv, logic e_mrv, logic [31:0] e_rd);
    vec_t r;
    r.rst = rst;   r.ir = ir;     r.ia = ia;       r.mr = mr;
    r.mw = mw;     r.ms = ms;     r.ma = ma;       r.md = md;
    r.e_ig = e_ig; r.e_mg = e_mg; r.e_en = e_en;   r.e_we = e_we;
    r.e_addr = e_addr; r.e_irv = e_irv; r.e_mrv = e_mrv; r.e_rd = e_rd;
    return r;
  endfunction

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_if;
    bit exp_if;

    for (int k = 0; k < 256; k++) sram_mem[k] = 32'(k * 32'h11);
    sram_mem[8] = 32'h1122_3344;
    bus.sram_rdata = '0;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

    //          rst ir ia        mr mw ms       ma          md              ig mg en we       addr        irv mrv rd
    vecs[0]  = v(1, 1, 32'h0,    1, 0, 4'h0, 32'h0,   32'h0,           0, 0, 0, 4'h0, 32'h0,   0, 0, 32'h0);
    vecs[1]  = v(1, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,           0, 0, 0, 4'h0, 32'h0,   0, 0, 32'h0);
    // fetch stream 0x0, 0x4, 0x8
    vecs[2]  = v(0, 1, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,           1, 0, 1, 4'h0, 32'h0,   0, 0, 32'h0);
    vecs[3]  = v(0, 1, 32'h4,    0, 0, 4'h0, 32'h0,   32'h0,           1, 0, 1, 4'h0, 32'h4,   1, 0, 32'h00);
    vecs[4]  = v(0, 1, 32'h8,    0, 0, 4'h0, 32'h0,   32'h0,           1, 0, 1, 4'h0, 32'h8,   1, 0, 32'h11);
    vecs[5]  = v(0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,           0, 0, 0, 4'h0, 32'h0,   1, 0, 32'h22);
    vecs[6]  = v(0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,           0, 0, 0, 4'h0, 32'h0,   0, 0, 32'h0);
    // byte write into 0x20, then read it back
    vecs[7]  = v(0, 0, 32'h0,    1, 1, 4'h2, 32'h20,  32'hAABBCCDD,    0, 1, 1, 4'h2, 32'h20,  0, 0, 32'h0);
    vecs[8]  = v(0, 0, 32'h0,    1, 0, 4'h0, 32'h20,  32'h0,           0, 1, 1, 4'h0, 32'h20,  0, 0, 32'h0);
    vecs[9]  = v(0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,           0, 0, 0, 4'h0, 32'h0,   0, 1, 32'h1122CC44);
    // reset mid-read: the 0xC fetch is dropped
    vecs[10] = v(0, 1, 32'hC,    0, 0, 4'h0, 32'h0,   32'h0,           1, 0, 1, 4'h0, 32'hC,   0, 0, 32'h0);
    vecs[11] = v(1, 1, 32'h10,   1, 0, 4'h0, 32'h100, 32'h0,           0, 0, 0, 4'h0, 32'h100, 0, 0, 32'h0);
    vecs[12] = v(0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,           0, 0, 0, 4'h0, 32'h0,   0, 0, 32'h0);
    vecs[13] = v(0, 1, 32'h10,   0, 0, 4'h0, 32'h0,   32'h0,           1, 0, 1, 4'h0, 32'h10,  0, 0, 32'h0);
    vecs[14] = v(0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,           0, 0, 0, 4'h0, 32'h0,   1, 0, 32'h44);
    // both request: MEM write wins, IF follows; write returns no rvalid
    vecs[15] = v(0, 1, 32'h14,   1, 1, 4'hF, 32'h30,  32'h12345678,    0, 1, 1, 4'hF, 32'h30,  0, 0, 32'h0);
    vecs[16] = v(0, 1, 32'h14,   0, 0, 4'h0, 32'h0,   32'h0,           1, 0, 1, 4'h0, 32'h14,  0, 0, 32'h0);
    vecs[17] = v(0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,           0, 0, 0, 4'h0, 32'h0,   1, 0, 32'h55);
    vecs[18] = v(0, 0, 32'h0,    1, 0, 4'h0, 32'h30,  32'h0,           0, 1, 1, 4'h0, 32'h30,  0, 0, 32'h0);
    vecs[19] = v(0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,           0, 0, 0, 4'h0, 32'h0,   0, 1, 32'h12345678);

    // -------------------------------------------------------------------------
    // Table-driven vectors, one clock cycle each
    // -------------------------------------------------------------------------
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ir, vecs[i].ia, vecs[i].mr, vecs[i].mw,
            vecs[i].ms, vecs[i].ma, vecs[i].md);
      #1;
      check($sformatf("v%0d if_gnt", i),     32'(bus.if_gnt),     32'(vecs[i].e_ig));
      check($sformatf("v%0d mem_gnt", i),    32'(bus.mem_gnt),    32'(vecs[i].e_mg));
      check($sformatf("v%0d sram_en", i),    32'(bus.sram_en),    32'(vecs[i].e_en));
      check($sformatf("v%0d sram_we", i),    32'(bus.sram_we),    32'(vecs[i].e_we));
      check($sformatf("v%0d sram_addr", i),  bus.sram_addr,       vecs[i].e_addr);
      check($sformatf("v%0d if_rvalid", i),  32'(bus.if_rvalid),  32'(vecs[i].e_irv));
      check($sformatf("v%0d mem_rvalid", i), 32'(bus.mem_rvalid), 32'(vecs[i].e_mrv));
      if (vecs[i].e_irv) check($sformatf("v%0d if_rdata", i),  bus.if_rdata,  vecs[i].e_rd);
      if (vecs[i].e_mrv) check($sformatf("v%0d mem_rdata", i), bus.mem_rdata, vecs[i].e_rd);
      if (vecs[i].e_mg && vecs[i].mw) check($sformatf("v%0d sram_wdata", i), bus.sram_wdata, vecs[i].md);
    end

    // -------------------------------------------------------------------------
    // Continuous contention: IF reads 0x40 (0x110), MEM reads 0x100 (0x440).
    // MEM for 4 cycles, then IF, repeating with period 5.
    // -------------------------------------------------------------------------
    prev_if = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
      #1;
      exp_if = ((c % 5) == 4);
      check($sformatf("cont%0d if_gnt", c),    32'(bus.if_gnt),  32'(exp_if));
      check($sformatf("cont%0d mem_gnt", c),   32'(bus.mem_gnt), 32'(!exp_if));
      check($sformatf("cont%0d sram_addr", c), bus.sram_addr,    exp_if ? 32'h40 : 32'h100);
      if (c > 0) begin
        check($sformatf("cont%0d if_rvalid", c),  32'(bus.if_rvalid),  32'(prev_if));
        check($sformatf("cont%0d mem_rvalid", c), 32'(bus.mem_rvalid), 32'(!prev_if));
        if (prev_if) check($sformatf("cont%0d if_rdata", c),  bus.if_rdata,  32'h110);
        else         check($sformatf("cont%0d mem_rdata", c), bus.mem_rdata, 32'h440);
      end
      prev_if = exp_if;
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    check("cont_tail if_rvalid",  32'(bus.if_rvalid),  32'(prev_if));
    check("cont_tail mem_rvalid", 32'(bus.mem_rvalid), 32'(!prev_if));
    check("cont_tail if_rdata",   bus.if_rdata,        32'h110);

    // -------------------------------------------------------------------------
    // Counter clear: 3 denials, IF drops for one cycle, then IF must wait a
    // full 4 further cycles before being forced through.
    // -------------------------------------------------------------------------
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive(1'b0, (c != 3), 32'h40, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
      #1;
      check($sformatf("clr%0d if_gnt", c),  32'(bus.if_gnt),  32'(c == 8));
      check($sformatf("clr%0d mem_gnt", c), 32'(bus.mem_gnt), 32'(c != 8));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    check("clr_tail if_rvalid",  32'(bus.if_rvalid),  32'd1);
    check("clr_tail mem_rvalid", 32'(bus.mem_rvalid), 32'd0);
    check("clr_tail if_rdata",   bus.if_rdata,        32'h110);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch port and the data-memory (MEM stage) port.
- Grants at most one access per cycle; requester is granted in the same cycle it requests.
- Routes the 1-cycle-latency read data back to whichever requester issued the read.
- Bounded-starvation priority: MEM wins by default; IF is forced through after a configurable number of consecutive denials.

Parameters:
- ADDR_W, 32, address width for both ports and the SRAM.
- DATA_W, 32, data width; DATA_W/8 byte strobes.
- STARVE_LIMIT, 4, consecutive denied IF-request cycles after which IF takes priority for one grant; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- mem_req  in  1  data access request
- mem_we  in  1  1 = write, 0 = read
- mem_wstrb  in  DATA_W/8  byte write strobes
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  write data
- mem_gnt  out  1  data request accepted this cycle (write completes at the clock edge)
- mem_rvalid  out  1  data read data valid
- mem_rdata  out  DATA_W  data read data
- sram_en  out  1  SRAM enable
- sram_we  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable

Behaviour:
- Grant logic is combinational from the requests and `starve_cnt`:
  - `force_if = (starve_cnt == STARVE_LIMIT)`
  - `if_gnt = if_req & (~mem_req | force_if)`
  - `mem_gnt = mem_req & ~if_gnt`
  - Both gnt signals are 0 while reset is high.
- SRAM drive:
  - `sram_en = if_gnt | mem_gnt`
  - `sram_addr` = `if_addr` when `if_gnt`, else `mem_addr`.
  - `sram_we` = `mem_wstrb` when `mem_gnt & mem_we`, else 0.
  - `sram_wdata = mem_wdata`.
  - With no grant: `sram_addr` = `mem_addr`, `sram_we` = 0.
- Requester contract:
  - Hold req, addr, we, wstrb and wdata stable until gnt is seen high.
  - Requests may change freely in the cycle after a grant.
  - Back-to-back grants to the same requester are allowed.
- Starvation counter `starve_cnt` (4 bits):
  - Cleared by reset, by `if_gnt`, or by `if_req == 0`.
  - Otherwise increments when `if_req & ~if_gnt`.
  - Saturates at STARVE_LIMIT.
- Response owner register `rsp_owner`, states NONE / IF / MEM:
  - Next state is IF on `if_gnt`; MEM on `mem_gnt & ~mem_we`; otherwise NONE.
  - Reset value is NONE.
- Read response path:
  - `if_rvalid = (rsp_owner == IF)`; `mem_rvalid = (rsp_owner == MEM)`.
  - `if_rdata = sram_rdata` and `mem_rdata = sram_rdata`, passthrough; meaningful only when the matching rvalid is high.
  - Latency: gnt in cycle N gives rvalid in cycle N+1.
  - Writes produce no rvalid.
- Simultaneous events:
  - Both requests high with `starve_cnt < STARVE_LIMIT`: MEM granted, IF counter increments.
  - Both high with counter at limit: IF granted, counter clears, MEM waits one cycle.
  - A new grant in cycle N+1 while the cycle-N response returns is legal; full throughput is 1 access per cycle.
- Reset values:
  - All gnt and rvalid outputs 0.
  - `sram_en` = 0, `sram_we` = 0.
  - `starve_cnt` = 0, `rsp_owner` = NONE.
- Reset mid-operation: a read granted in the cycle before reset asserts is dropped. No rvalid is produced in the cycle after reset is sampled.
- No internal buffering: at most one outstanding read, always retired in the next cycle.

Test Plan:
- IF only: `if_req=1`, `if_addr=0x0,0x4,0x8` on consecutive cycles, SRAM preloaded with `mem[k]=k*0x11` → `if_gnt` is 1 every cycle; `if_rvalid` rises one cycle later, returning 0x00, 0x11, 0x22 (word index); `mem_rvalid` stays 0.
- Contention: `if_req` and `mem_req` (read at 0x100) both held continuously, STARVE_LIMIT=4 → `mem_gnt` for 4 cycles, then `if_gnt` on cycle 5; pattern repeats with period 5; each `rvalid` lands on the correct port.
- Byte write: `mem_req=1`, `mem_we=1`, `mem_wstrb=4'b0010`, `mem_addr=0x20`, `mem_wdata=0xAABBCCDD` over old word 0x11223344 → `sram_we=4'b0010`, `mem_gnt=1`, no `mem_rvalid`; a later read of 0x20 returns 0x1122CC44.
- Counter clear: `if_req` denied 3 cycles, then dropped for 1 cycle, then re-asserted with `mem_req` held → IF waits a full 4 further cycles; `starve_cnt` restarted from 0.
- Reset mid-read: `if_gnt` in cycle N, reset high in cycle N+1 → `if_rvalid=0` in N+1; `sram_en=0` and all gnt outputs 0 while reset is high; normal operation resumes the cycle after reset deasserts.
